pixel_writer: RTL and testbench
===============================

Name: pixel_writer

Overview:
- Write side of the frame pixel memory that the VGA pixel loader reads.
- Takes an 8-bit byte stream (R, G, B order) and packs each three bytes into one 24-bit RGB word.
- Writes each word to sequential memory addresses using the memory's wren/address/data port.
- Keeps a running 32-bit sum of the written pixels, computed the same way as the bench's read-back hash, so the frame loaded and the frame displayed can be compared directly.

Parameters:
ADDR_W, 11, memory address width (2048 words).
FRAME_PIXELS, 2048, words written per frame; legal range 1..2**ADDR_W.
SUM_W, 32, checksum width.

Ports:
CLOCK_50  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse that begins a frame load.
byte_valid  in  1  byte_data is valid this cycle.
byte_data  in  8  stream byte; order is R, G, B.
byte_ready  out  1  block accepts a byte this cycle.
wren  out  1  memory write enable.
address  out  ADDR_W  memory write address.
data  out  24  memory write data, {R,G,B}.
busy  out  1  a frame load is in progress.
done  out  1  frame complete; held until the next start or reset.
checksum  out  SUM_W  sum of all words written this frame, modulo 2**SUM_W.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - State goes to IDLE.
  - wren=0, address=0, data=0, byte_ready=0, busy=0, done=0, checksum=0.
- Reset mid-frame: the next cycle shows the reset values. No write is issued in the reset cycle or the cycle after it.
- Byte handshake: a byte transfers only in a cycle where byte_valid && byte_ready. byte_valid may be held high across many cycles.
- States:
  - IDLE: byte_ready=0.
    - start -> CAP_R; clear address, checksum and done; set busy.
  - CAP_R: byte_ready=1.
    - On a transfer, latch R -> CAP_G.
  - CAP_G: byte_ready=1.
    - On a transfer, latch G -> CAP_B.
  - CAP_B: byte_ready=1.
    - On a transfer, drive data={R,G,B byte}, set wren=1 for the next cycle only -> WRITE.
  - WRITE: wren=1 for exactly one cycle, with address and data stable. byte_ready=0, so no byte is accepted.
    - checksum <= checksum + zero-extended data.
    - If address==FRAME_PIXELS-1: go to DONE; address holds its value.
    - Otherwise: address increments and the state returns to CAP_R.
  - DONE: busy=0, done=1, byte_ready=0.
    - start -> CAP_R, with the same clears as from IDLE.
- Throughput: at most one pixel per 4 cycles. Every word produces exactly one wren pulse.
- Address:
  - Never wraps within a frame; it stops at FRAME_PIXELS-1.
  - After DONE it holds the last written address until the next start.
- start while busy (CAP_* or WRITE): ignored. There is no restart and no effect on the current frame.
- start and reset in the same cycle: reset wins.
- Checksum: unsigned addition that wraps modulo 2**SUM_W. It is updated in the same cycle as the wren pulse, so the new value is visible one cycle after the pulse.
- byte_valid in IDLE, DONE or WRITE: the byte is not consumed. The source holds it until byte_ready.
- data holds the last written word between writes.

Decomposition:
- Shared package pixel_pkg:
  - State enum: IDLE, CAP_R, CAP_G, CAP_B, WRITE, DONE.
  - RGB_W=24.
  - Byte-lane index constants for R, G and B.
- No sub-module: a single FSM with the datapath in the same module. The checksum adder stays inline.

Test Plan:
- reset high for 3 cycles, then low -> all outputs zero, byte_ready=0, no wren.
- start, then bytes 0x11,0x22,0x33 sent back-to-back -> exactly one wren pulse with address=0, data=0x112233; checksum=0x00112233 on the following cycle.
- FRAME_PIXELS=4; 12 bytes, each pixel 0xFFFFFF -> wren at addresses 0..3, done=1, busy=0, checksum=0x03FFFFFC.
- byte_valid toggled randomly (50%) over 64 pixels with data=i*0x010203 -> addresses 0..63 in order, no pixel lost or duplicated, checksum equals the sum modelled in the bench.
- reset asserted after the G byte of pixel 5 -> no wren for pixel 5, all outputs return to reset values; a new start writes from address 0 again.
- start pulsed during CAP_G, and in the same cycle as reset -> the frame continues unchanged in the first case; reset state in the second.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared definitions for the frame pixel memory write path.
// Lane constants give the byte position of each colour inside a packed word.
package pixel_pkg;

    localparam int RGB_W  = 24;
    localparam int BYTE_W = 8;

    localparam int LANE_R = 2;
    localparam int LANE_G = 1;
    localparam int LANE_B = 0;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t CAP_R = 3'd1;
    localparam state_t CAP_G = 3'd2;
    localparam state_t CAP_B = 3'd3;
    localparam state_t WRITE = 3'd4;
    localparam state_t DONE  = 3'd5;

    function automatic logic [RGB_W-1:0] pack_rgb(
        input logic [BYTE_W-1:0] r,
        input logic [BYTE_W-1:0] g,
        input logic [BYTE_W-1:0] b
    );
        logic [RGB_W-1:0] w;
        w = '0;
        w[LANE_R*BYTE_W +: BYTE_W] = r;
        w[LANE_G*BYTE_W +: BYTE_W] = g;
        w[LANE_B*BYTE_W +: BYTE_W] = b;
        return w;
    endfunction

endpackage

// File: rtl/pixel_writer.sv
// Packs an R,G,B byte stream into 24-bit words and writes one frame to memory,
// keeping a running sum of written words for comparison with the display side.
//
// state | meaning
// IDLE  | waiting for start, no frame loaded yet
// CAP_R | waiting for the red byte
// CAP_G | waiting for the green byte
// CAP_B | waiting for the blue byte, word is written on transfer
// WRITE | wren high for this one cycle, checksum accumulates
// DONE  | frame complete, address/data/checksum held until next start
module pixel_writer
    import pixel_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int FRAME_PIXELS = 2048,
    parameter int SUM_W        = 32
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wren,
    output logic [ADDR_W-1:0] address,
    output logic [RGB_W-1:0]  data,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  checksum
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    state_t     state;
    logic [7:0] r_byte;
    logic [7:0] g_byte;
    logic       xfer;

    always_comb begin
        byte_ready = (state == CAP_R) || (state == CAP_G) || (state == CAP_B);
    end

    assign xfer = byte_valid && byte_ready;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            r_byte   <= '0;
            g_byte   <= '0;
            wren     <= 1'b0;
            address  <= '0;
            data     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            checksum <= '0;
        end else begin
            wren <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= CAP_R;
                        address  <= '0;
                        checksum <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CAP_R: begin
                    if (xfer) begin
                        r_byte <= byte_data;
                        state  <= CAP_G;
                    end
                end
                CAP_G: begin
                    if (xfer) begin
                        g_byte <= byte_data;
                        state  <= CAP_B;
                    end
                end
                CAP_B: begin
                    if (xfer) begin
                        data  <= pack_rgb(r_byte, g_byte, byte_data);
                        wren  <= 1'b1;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    checksum <= checksum + SUM_W'(data);
                    // Address stops on the last word so DONE reports where the frame ended.
                    if (address == LAST_ADDR) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        address <= address + ADDR_W'(1);
                        state   <= CAP_R;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: a full-size instance plus a 4-pixel frame
// instance sharing the same stimulus.
module tb_pixel_writer;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;

    logic        byte_ready, wren, busy, done;
    logic [10:0] address;
    logic [23:0] data;
    logic [31:0] checksum;

    logic        ready4, wren4, busy4, done4;
    logic [10:0] addr4;
    logic [23:0] data4;
    logic [31:0] sum4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] wr_addr[$];
    logic [23:0] wr_data[$];
    logic [10:0] wr4_addr[$];

    pixel_writer #(.ADDR_W(11), .FRAME_PIXELS(2048), .SUM_W(32)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wren(wren), .address(address), .data(data),
        .busy(busy), .done(done), .checksum(checksum)
    );

    pixel_writer #(.ADDR_W(11), .FRAME_PIXELS(4), .SUM_W(32)) dut4 (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(ready4),
        .wren(wren4), .address(addr4), .data(data4),
        .busy(busy4), .done(done4), .checksum(sum4)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (wren) begin
            wr_addr.push_back(address);
            wr_data.push_back(data);
        end
        if (wren4) wr4_addr.push_back(addr4);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        tick(n);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr4_addr.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        logic acc;
        int   gaps;
        gaps = 0;
        if (rnd) begin
            while ($urandom_range(1, 0) == 1 && gaps < 8) begin
                byte_valid = 1'b0;
                tick(1);
                gaps++;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge CLOCK_50);
            acc = byte_ready;
            @(posedge CLOCK_50);
            #1;
        end
        byte_valid = 1'b0;
        if (!acc) chk("byte_accept_timeout", acc, 1);
    endtask

    task automatic send_pixel(input logic [23:0] p, input bit rnd);
        send_byte(p[23:16], rnd);
        send_byte(p[15:8], rnd);
        send_byte(p[7:0], rnd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sum;
        logic [23:0] p;

        // Reset state
        tick(3);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("rst_wren", wren, 0);
        chk("rst_address", address, 0);
        chk("rst_data", data, 0);
        chk("rst_ready", byte_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", checksum, 0);
        @(posedge CLOCK_50); #1;

        // Single pixel, back-to-back bytes
        clear_log();
        pulse_start();
        send_pixel(24'h112233, 0);
        @(negedge CLOCK_50);
        chk("p1_wren", wren, 1);
        chk("p1_address", address, 0);
        chk("p1_data", data, 24'h112233);
        chk("p1_ready_in_write", byte_ready, 0);
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        chk("p1_checksum", checksum, 32'h0011_2233);
        chk("p1_wren_single", wren, 0);
        chk("p1_write_count", wr_addr.size(), 1);
        @(posedge CLOCK_50); #1;

        // Four-pixel frame of white on the small instance
        do_reset(1);
        clear_log();
        pulse_start();
        for (int i = 0; i < 4; i++) send_pixel(24'hFFFFFF, 0);
        tick(2);
        @(negedge CLOCK_50);
        chk("f4_done", done4, 1);
        chk("f4_busy", busy4, 0);
        chk("f4_checksum", sum4, 32'h03FF_FFFC);
        chk("f4_addr_hold", addr4, 3);
        chk("f4_data_hold", data4, 24'hFFFFFF);
        chk("f4_write_count", wr4_addr.size(), 4);
        for (int i = 0; i < wr4_addr.size() && i < 4; i++) chk("f4_write_addr", wr4_addr[i], i);
        @(posedge CLOCK_50); #1;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        tick(2);
        @(negedge CLOCK_50);
        chk("f4_ready_in_done", ready4, 0);
        chk("f4_done_held", done4, 1);
        chk("f4_no_extra_write", wr4_addr.size(), 4);
        @(posedge CLOCK_50); #1;
        byte_valid = 1'b0;
        pulse_start();
        @(negedge CLOCK_50);
        chk("f4_restart_done", done4, 0);
        chk("f4_restart_busy", busy4, 1);
        chk("f4_restart_checksum", sum4, 0);
        chk("f4_restart_addr", addr4, 0);
        @(posedge CLOCK_50); #1;

        // 64 pixels with random valid gaps
        do_reset(1);
        clear_log();
        pulse_start();
        sum = '0;
        for (int i = 0; i < 64; i++) begin
            p = 24'(i * 24'h010203);
            sum = sum + {8'h00, p};
            send_pixel(p, 1);
        end
        tick(1);
        @(negedge CLOCK_50);
        chk("r64_write_count", wr_addr.size(), 64);
        for (int i = 0; i < wr_addr.size() && i < 64; i++) begin
            chk("r64_addr", wr_addr[i], i);
            chk("r64_data", wr_data[i], 24'(i * 24'h010203));
        end
        chk("r64_checksum", checksum, sum);
        chk("r64_busy", busy, 1);
        @(posedge CLOCK_50); #1;

        // Reset after the G byte of pixel 5
        do_reset(1);
        clear_log();
        pulse_start();
        for (int i = 0; i < 5; i++) send_pixel(24'h102030 + 24'(i), 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("mr_wren", wren, 0);
        chk("mr_address", address, 0);
        chk("mr_data", data, 0);
        chk("mr_checksum", checksum, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_ready", byte_ready, 0);
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        chk("mr_wren_after", wren, 0);
        chk("mr_write_count", wr_addr.size(), 5);
        @(posedge CLOCK_50); #1;
        clear_log();
        pulse_start();
        send_pixel(24'hABCDEF, 0);
        @(negedge CLOCK_50);
        chk("mr_new_wren", wren, 1);
        chk("mr_new_address", address, 0);
        chk("mr_new_data", data, 24'hABCDEF);
        @(posedge CLOCK_50); #1;

        // start during CAP_G is ignored; start with reset gives reset state
        do_reset(1);
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        pulse_start();
        @(negedge CLOCK_50);
        chk("sb_busy", busy, 1);
        chk("sb_ready", byte_ready, 1);
        @(posedge CLOCK_50); #1;
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        @(negedge CLOCK_50);
        chk("sb_p0_wren", wren, 1);
        chk("sb_p0_address", address, 0);
        chk("sb_p0_data", data, 24'h010203);
        @(posedge CLOCK_50); #1;
        send_pixel(24'h040506, 0);
        @(negedge CLOCK_50);
        chk("sb_p1_address", address, 1);
        chk("sb_p1_data", data, 24'h040506);
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        chk("sb_checksum", checksum, 32'h0005_0709);
        chk("sb_write_count", wr_addr.size(), 2);
        @(posedge CLOCK_50); #1;
        start = 1'b1;
        reset = 1'b1;
        tick(1);
        start = 1'b0;
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("sr_busy", busy, 0);
        chk("sr_done", done, 0);
        chk("sr_address", address, 0);
        chk("sr_checksum", checksum, 0);
        chk("sr_ready", byte_ready, 0);
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        chk("sr_idle_ready", byte_ready, 0);
        chk("sr_idle_busy", busy, 0);
        @(posedge CLOCK_50); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
